muldiv_seq: RTL

- Multi-cycle multiply/divide unit owning the HI/LO special registers.
- Sits beside the ALU in the execute stage and is driven by main-decoder outputs (spregwrite, mf, resmove, spaddr) plus funct.
- Sequences MULT/MULTU/DIV/DIVU over WIDTH iterations and services MFHI/MFLO/MTHI/MTLO.
- Raises a stall to the pipeline whenever HI/LO are requested while an operation is in flight.

---
 rtl/muldiv_seq_pkg.sv | 36 +++
 rtl/muldiv_seq_signfix.sv | 25 ++
 rtl/muldiv_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared types and funct encodings for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } muldiv_state_t;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [3:0] GRP_MULDIV = 4'b0110;
  localparam logic [3:0] GRP_HILO   = 4'b0100;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_seq_signfix.sv
// Conditional negate of a {hi,lo} pair: whole product for multiply,
// remainder (hi) and quotient (lo) independently for divide.
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] pair,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] result
);

  always_comb begin
    result = pair;
    if (is_div) begin
      if (sign_a)
        result[2*WIDTH-1:WIDTH] = -pair[2*WIDTH-1:WIDTH];
      if (sign_a ^ sign_b)
        result[WIDTH-1:0] = -pair[WIDTH-1:0];
    end else if (sign_a ^ sign_b) begin
      result = -pair;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning HI/LO, with MFHI/MFLO/MTHI/MTLO.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply (IDLE -> FIX).
module muldiv_seq
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mt_req,
  input  logic             mf_req,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNTW = $clog2(WIDTH) + 1;
  localparam int unsigned W2   = 2 * WIDTH;

  muldiv_state_t    state, state_nx;
  logic [CNTW-1:0]  cnt, cnt_nx;
  logic [W2-1:0]    acc, acc_nx;
  logic [WIDTH-1:0] opd, opd_nx;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic             sa, sa_nx, sb, sb_nx;
  logic             isdiv, isdiv_nx, divz, divz_nx;

  logic             go, mt_go, in_signed, in_sa, in_sb;
  logic [W2-1:0]    absp, fixp;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [W2-1:0]    mul_next, div_next;

  assign go        = start & (funct[5:2] == GRP_MULDIV);
  assign mt_go     = mt_req & (funct[5:2] == GRP_HILO) & funct[0];
  assign in_signed = op_is_signed(funct[1:0]);
  assign in_sa     = in_signed & srca[WIDTH-1];
  assign in_sb     = in_signed & srcb[WIDTH-1];

  // Divide-mode negate reused for abs: lo is negated iff sa^(sa^sb) = sb.
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs (
    .pair   ({srca, srcb}),
    .sign_a (in_sa),
    .sign_b (in_sa ^ in_sb),
    .is_div (1'b1),
    .result (absp)
  );

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix (
    .pair   (acc),
    .sign_a (sa),
    .sign_b (sb),
    .is_div (isdiv),
    .result (fixp)
  );

  assign mag_a = absp[W2-1:WIDTH];
  assign mag_b = absp[WIDTH-1:0];

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
  assign div_trial = acc[W2-1:WIDTH-1] - {1'b0, opd};
  assign div_next  = div_trial[WIDTH] ? {acc[W2-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign busy    = (state != S_IDLE);
  assign stall   = (start | mt_req | mf_req) & busy;
  assign mf_data = funct[1] ? lo : hi;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    acc_nx   = acc;
    opd_nx   = opd;
    sa_nx    = sa;
    sb_nx    = sb;
    isdiv_nx = isdiv;
    divz_nx  = divz;
    hi_nx    = hi;
    lo_nx    = lo;
    case (state)
      S_IDLE: begin
        if (go) begin
          sa_nx    = in_sa;
          sb_nx    = in_sb;
          isdiv_nx = op_is_div(funct[1:0]);
          divz_nx  = op_is_div(funct[1:0]) & (srcb == '0);
          cnt_nx   = CNTW'(WIDTH);
          if (op_is_div(funct[1:0])) begin
            opd_nx   = mag_b;
            acc_nx   = {{WIDTH{1'b0}}, mag_a};
            state_nx = S_DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            opd_nx   = mag_a;
            acc_nx   = W2'(mag_a) * W2'(mag_b);
            state_nx = S_FIX;
`else
            opd_nx   = mag_a;
            acc_nx   = {{WIDTH{1'b0}}, mag_b};
            state_nx = S_MUL;
`endif
          end
        end else if (mt_go) begin
          if (funct[1])
            lo_nx = srca;
          else
            hi_nx = srca;
        end
      end
      S_MUL: begin
        acc_nx = mul_next;
        cnt_nx = cnt - CNTW'(1);
        if (cnt == CNTW'(1))
          state_nx = S_FIX;
      end
      S_DIV: begin
        acc_nx = div_next;
        cnt_nx = cnt - CNTW'(1);
        if (cnt == CNTW'(1))
          state_nx = S_FIX;
      end
      S_FIX: begin
        hi_nx    = fixp[W2-1:WIDTH];
        lo_nx    = divz ? '1 : fixp[WIDTH-1:0];
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      acc   <= '0;
      opd   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      isdiv <= 1'b0;
      divz  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      cnt   <= cnt_nx;
      acc   <= acc_nx;
      opd   <= opd_nx;
      sa    <= sa_nx;
      sb    <= sb_nx;
      isdiv <= isdiv_nx;
      divz  <= divz_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
    end
  end

endmodule
